// File: rtl/bus_arbiter_if.sv
// Register-bus arbitration interface: requester handshakes and register-slot enables.
// The slave modport is the arbiter's view; the master modport is the requester side.
interface bus_arbiter_if #(
    parameter int NumReq   = 4,
    parameter int SelWidth = 3
);
    localparam int NumSlots = 2 ** SelWidth;

    logic [NumReq-1:0]          Req;
    logic [NumReq*SelWidth-1:0] ReqSrc;
    logic [NumReq*SelWidth-1:0] ReqDst;
    logic [NumReq-1:0]          Grant;
    logic [NumReq-1:0]          Done;
    logic [NumSlots-1:0]        RegOut;
    logic [NumSlots-1:0]        RegIn;
    logic                       Busy;
    logic [15:0]                XferCount;

    modport slave (
        input  Req, ReqSrc, ReqDst,
        output Grant, Done, RegOut, RegIn, Busy, XferCount
    );

    modport master (
        output Req, ReqSrc, ReqDst,
        input  Grant, Done, RegOut, RegIn, Busy, XferCount
    );
endinterface

// File: rtl/bus_arbiter.sv
// Round-robin arbiter for a shared 16-bit tri-state register bus, one register move per grant.
// Define BUS_TURNAROUND_EN to insert one idle TURN cycle after every transfer.
module bus_arbiter #(
    parameter int NumReq   = 4,
    parameter int SelWidth = 3
) (
    input  logic          Clk,
    input  logic          Rst,
    bus_arbiter_if.slave  bus
);
    localparam int NumSlots = 2 ** SelWidth;
    localparam int PtrW     = (NumReq > 1) ? $clog2(NumReq) : 1;

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] XFER = 2'd1;
    localparam logic [1:0] TURN = 2'd2;

    logic [1:0]          r_state;
    logic [PtrW-1:0]     r_ptr;
    logic [NumReq-1:0]   r_grant;
    logic [NumSlots-1:0] r_reg_out;
    logic [NumSlots-1:0] r_reg_in;
    logic [15:0]         r_xfer_count;

    logic [SelWidth-1:0] w_src  [NumReq];
    logic [SelWidth-1:0] w_dst  [NumReq];
    logic [PtrW-1:0]     w_cand [NumReq];
    logic                w_found;
    logic [PtrW-1:0]     w_win;

    // w_cand[k] is the k-th requester visited when searching upward from the pointer.
    generate
        for (genvar gi = 0; gi < NumReq; gi++) begin : g_slice
            assign w_src[gi]  = bus.ReqSrc[gi*SelWidth +: SelWidth];
            assign w_dst[gi]  = bus.ReqDst[gi*SelWidth +: SelWidth];
            assign w_cand[gi] = (int'(r_ptr) + gi >= NumReq)
                              ? PtrW'(int'(r_ptr) + gi - NumReq)
                              : PtrW'(int'(r_ptr) + gi);
        end
    endgenerate

    always_comb begin
        w_found = 1'b0;
        w_win   = '0;
        for (int k = 0; k < NumReq; k++) begin
            if (!w_found && bus.Req[w_cand[k]]) begin
                w_found = 1'b1;
                w_win   = w_cand[k];
            end
        end
    end

    always_ff @(posedge Clk) begin
        if (!Rst) begin
            r_state      <= IDLE;
            r_ptr        <= '0;
            r_grant      <= '0;
            r_reg_out    <= '0;
            r_reg_in     <= '0;
            r_xfer_count <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_found) begin
                        r_state <= XFER;
                        r_grant <= NumReq'(1) << w_win;
                        // A self-move would drive and capture the same slot; leave the bus alone.
                        if (w_src[w_win] != w_dst[w_win]) begin
                            r_reg_out <= NumSlots'(1) << w_src[w_win];
                            r_reg_in  <= NumSlots'(1) << w_dst[w_win];
                        end
                        r_ptr <= (int'(w_win) == NumReq - 1) ? '0 : w_win + 1'b1;
                    end
                end
                XFER: begin
                    r_grant      <= '0;
                    r_reg_out    <= '0;
                    r_reg_in     <= '0;
                    r_xfer_count <= r_xfer_count + 16'd1;
`ifdef BUS_TURNAROUND_EN
                    r_state      <= TURN;
`else
                    r_state      <= IDLE;
`endif
                end
                TURN: r_state <= IDLE;
                default: r_state <= IDLE;
            endcase
        end
    end

    assign bus.Grant     = r_grant;
    assign bus.Done      = r_grant;
    assign bus.RegOut    = r_reg_out;
    assign bus.RegIn     = r_reg_in;
    assign bus.Busy      = (r_state != IDLE);
    assign bus.XferCount = r_xfer_count;
endmodule
